vram_rect_fill: RTL and testbench

//  CPU-triggered rectangle fill engine that writes pixel colours into the framebuffer

---
 rtl/vram_rect_fill.sv | 174 +++++++++++++++++
 tb/tb_vram_rect_fill.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: walks a clipped rectangle row-major and issues one
// byte write per in-bounds pixel on the display-side RAM port.
module vram_rect_fill #(
  parameter logic [15:0] BASE_ADDR = 16'h0200,
  parameter int unsigned WIDTH_PX  = 32,
  parameter int unsigned HEIGHT_PX = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  x0_i,
  input  logic [7:0]  y0_i,
  input  logic [7:0]  w_i,
  input  logic [7:0]  h_i,
  input  logic [7:0]  color_i,
  input  logic        mem_grant_i,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_wren_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CW = 9;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cx_q, cx_d;
  logic [CW-1:0]   cy_q, cy_d;
  logic [CW-1:0]   x0_q, x0_d;
  logic [CW-1:0]   xe_q, xe_d;
  logic [CW-1:0]   ye_q, ye_d;
  logic [DW-1:0]   color_q, color_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic            mem_wren_q, mem_wren_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [CW-1:0]   nx_c, ny_c;
  logic            last_c;
  logic            consumed_c;

  // Pixel byte address; 16-bit sum wraps by design.
  function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(BASE_ADDR + AW'(y) * AW'(WIDTH_PX) + AW'(x));
  endfunction

  // Clip test on 9-bit coordinates.
  function automatic logic in_bounds(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (x < CW'(WIDTH_PX)) && (y < CW'(HEIGHT_PX));
  endfunction

  // Next candidate in row-major order and end-of-rectangle detect.
  always_comb begin
    last_c     = (cx_q == xe_q) && (cy_q == ye_q);
    consumed_c = !mem_wren_q || mem_grant_i;
    if (cx_q == xe_q) begin
      nx_c = x0_q;
      ny_c = cy_q + CW'(1);
    end else begin
      nx_c = cx_q + CW'(1);
      ny_c = cy_q;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    x0_d       = x0_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    color_d    = color_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wren_d = mem_wren_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        mem_wren_d = 1'b0;
        if (start_i) begin
          x0_d       = CW'(x0_i);
          xe_d       = CW'(x0_i) + CW'(w_i) - CW'(1);
          ye_d       = CW'(y0_i) + CW'(h_i) - CW'(1);
          color_d    = color_i;
          mem_data_d = color_i;
          cx_d       = CW'(x0_i);
          cy_d       = CW'(y0_i);
          if ((w_i == 8'd0) || (h_i == 8'd0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = RUN;
            mem_wren_d = in_bounds(CW'(x0_i), CW'(y0_i));
            mem_addr_d = pix_addr(CW'(x0_i), CW'(y0_i));
          end
        end
      end
      RUN: begin
        if (consumed_c) begin
          if (last_c) begin
            state_d    = DONE;
            done_d     = 1'b1;
            mem_wren_d = 1'b0;
          end else begin
            cx_d       = nx_c;
            cy_d       = ny_c;
            mem_wren_d = in_bounds(nx_c, ny_c);
            mem_addr_d = pix_addr(nx_c, ny_c);
            mem_data_d = color_q;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        mem_wren_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        mem_wren_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      x0_q       <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      color_q    <= '0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      x0_q       <= x0_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      color_q    <= color_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_wren_o = mem_wren_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Bench for vram_rect_fill: a pixel-list model predicts every accepted write
// and the done cycle; directed fills pin the model with literal addresses.
module tb_vram_rect_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  x0, y0, w, h, color;
  logic        grant;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  vram_rect_fill dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .x0_i        (x0),
    .y0_i        (y0),
    .w_i         (w),
    .h_i         (h),
    .color_i     (color),
    .mem_grant_i (grant),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_wren_o  (mem_wren),
    .busy_o      (busy),
    .done_o      (done)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  wr_t         exp_q[$];
  logic [15:0] acc_log[$];
  logic [15:0] exp_list[$];
  bit          exp_busy = 1'b0;
  bit          armed    = 1'b0;
  int          t_start  = 0;
  int          n_cand   = 0;
  int          stalls   = 0;
  int          done_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a start is taken only when the engine is idle; expected writes
  // are the in-bounds pixels of the rectangle in row-major order.
  task automatic model_start(input int mx0, input int my0, input int mw, input int mh, input logic [7:0] mc);
    if (!exp_busy && (cyc != done_cyc + 1)) begin
      exp_q.delete();
      for (int r = 0; r < mh; r++) begin
        for (int c = 0; c < mw; c++) begin
          int px;
          int py;
          px = mx0 + c;
          py = my0 + r;
          if (px < 32 && py < 32) exp_q.push_back('{a: 16'(512 + py * 32 + px), d: mc});
        end
      end
      n_cand   = mw * mh;
      stalls   = 0;
      t_start  = cyc;
      exp_busy = 1'b1;
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      if (!exp_busy) begin
        chk("idle_wren", 32'(mem_wren), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
      end else begin
        bit exp_done;
        exp_done = (cyc == t_start + n_cand + stalls);
        chk("busy", 32'(busy), 32'd1);
        chk("done", 32'(done), 32'(exp_done));
        if (mem_wren) begin
          chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            chk("addr", 32'(mem_addr), 32'(exp_q[0].a));
            chk("data", 32'(mem_data), 32'(exp_q[0].d));
            if (grant) begin
              void'(exp_q.pop_front());
              acc_log.push_back(mem_addr);
            end else begin
              stalls++;
            end
          end
        end
        if (exp_done) begin
          chk("done_wren", 32'(mem_wren), 32'd0);
          chk("writes_left", 32'(exp_q.size()), 32'd0);
          exp_busy = 1'b0;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sw,
                          input logic [7:0] sh, input logic [7:0] sc);
    @(posedge clk); #1;
    start = 1'b1; x0 = sx; y0 = sy; w = sw; h = sh; color = sc;
    @(posedge clk); #1;
    start = 1'b0;
    model_start(int'(sx), int'(sy), int'(sw), int'(sh), sc);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (exp_busy && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_timeout"}, 32'(exp_busy), 32'd0);
    exp_busy = 1'b0;
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_count"}, 32'(acc_log.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < acc_log.size(); i++)
      chk({nm, "_log"}, 32'(acc_log[i]), 32'(exp_list[i]));
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_addr"}, 32'(mem_addr), 32'h0200);
    chk({nm, "_data"}, 32'(mem_data), 32'h00);
    chk({nm, "_wren"}, 32'(mem_wren), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; grant = 1'b1;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    repeat (2) @(posedge clk);
    #1 check_reset("rst0");
    @(posedge clk); #1;
    rst = 1'b0;
    armed = 1'b1;

    // Basic 2x2 fill.
    acc_log.delete();
    do_start(8'd2, 8'd3, 8'd2, 8'd2, 8'h05);
    wait_done("t1");
    exp_list = '{16'h0262, 16'h0263, 16'h0282, 16'h0283};
    check_log("t1");
    chk("t1_lat", 32'(done_cyc - t_start), 32'd4);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Grant withheld for three cycles on the second pixel.
    acc_log.delete();
    do_start(8'd2, 8'd3, 8'd2, 8'd2, 8'h05);
    @(posedge clk); #1 grant = 1'b0;
    repeat (3) @(posedge clk);
    #1 grant = 1'b1;
    wait_done("t2");
    check_log("t2");
    chk("t2_lat", 32'(done_cyc - t_start), 32'd7);

    // Rectangle crossing the right and bottom edges.
    acc_log.delete();
    do_start(8'd30, 8'd31, 8'd4, 8'd2, 8'h3C);
    wait_done("t3");
    exp_list = '{16'h05FE, 16'h05FF};
    check_log("t3");
    chk("t3_lat", 32'(done_cyc - t_start), 32'd8);

    // Empty rectangle.
    acc_log.delete();
    do_start(8'd7, 8'd7, 8'd0, 8'd5, 8'hFF);
    wait_done("t4");
    exp_list.delete();
    check_log("t4");
    chk("t4_lat", 32'(done_cyc - t_start), 32'd0);

    // Second start while busy is dropped.
    acc_log.delete();
    do_start(8'd1, 8'd1, 8'd3, 8'd1, 8'hAA);
    do_start(8'd10, 8'd10, 8'd2, 8'd2, 8'h55);
    wait_done("t5");
    exp_list = '{16'h0221, 16'h0222, 16'h0223};
    check_log("t5");
    chk("t5_lat", 32'(done_cyc - t_start), 32'd3);
    repeat (4) @(posedge clk);

    // Reset in the middle of a large fill, then a fresh fill.
    do_start(8'd0, 8'd0, 8'd8, 8'd8, 8'h11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    exp_busy = 1'b0;
    exp_q.delete();
    check_reset("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    acc_log.delete();
    do_start(8'd5, 8'd0, 8'd1, 8'd2, 8'h33);
    wait_done("t6");
    exp_list = '{16'h0205, 16'h0225};
    check_log("t6");
    chk("t6_lat", 32'(done_cyc - t_start), 32'd2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
